proc_core: RTL and testbench
============================

// Module: proc_core
// PURPOSE
//  Byte-stream change-detect core: samples an 8-bit input every clock,
//  delays it through a fixed-latency pipeline, and emits a value on data_out
//  with a one-cycle valid strobe only when that value differs from the last
//  emitted one. Sits between a raw byte source and event-driven consumers.
// PARAMETERS
//  DATA_W   8  width of data_in/data_out
//  LATENCY  2  input-to-compare pipeline depth in cycles; legal range 1..4
// PORTS
//  clk       in   1       single clock; all state updates on the rising edge
//  reset     in   1       asynchronous, active-low reset (0 = reset asserted)
//  data_in   in   DATA_W  sample, captured every rising edge
//  data_out  out  DATA_W  last emitted value; registered output
//  valid     out  1       1-cycle strobe: data_out was updated this cycle
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): all pipeline data regs = 0,
//    stage-valid bits = 0, data_out = 0, valid = 0, have_last = 0.
//  - Pipeline: LATENCY stages, each holding data plus a stage-valid bit.
//    Stage 0 takes data_in with valid=1 on every edge out of reset.
//    Stages shift every cycle; there is no stall and no back-pressure.
//  - Compare point is the last stage (tail). On each edge where the tail is
//    valid, and either have_last=0 or tail data != data_out:
//    data_out <= tail data; valid <= 1; have_last <= 1.
//    Otherwise data_out holds and valid <= 0.
//  - Latency: a new input value sampled at edge N appears on data_out with
//    valid=1 after edge N+LATENCY (with CORE_DEGLITCH_EN, after N+LATENCY+1).
//  - First sample after reset is always emitted, including 0x00.
//  - A constant input produces exactly one valid pulse.
//  - A value changing every cycle produces a valid pulse every cycle.
//  - A-B-A produces three pulses: comparison is against the last emitted
//    value only.
//  - Reset asserted mid-stream clears everything immediately, including
//    valid. The first post-reset sample is re-emitted even when it equals
//    the pre-reset value.
//  - Outputs are pure registers; there is no combinational path from
//    data_in to the outputs.
// CONFIGURATION
//  CORE_DEGLITCH_EN defined: a candidate tail value is emitted only if it
//    equals the tail value of the previous cycle (stable for 2 samples).
//    This adds one cycle of latency and suppresses single-cycle glitches.
//    The first post-reset sample also needs 2 equal consecutive samples.
//  CORE_DEGLITCH_EN undefined: behaviour exactly as in BEHAVIOUR.
// STRUCTURE
//  - core_pkg: DATA_W default, LATENCY_MAX=4, typedef data_t
//    (logic [DATA_W-1:0]), typedef struct {data_t d; logic v;} stage_t.
//  - Sub-module core_stage: one stage_t pipeline register with async
//    active-low reset. proc_core instantiates LATENCY of them in a
//    generate loop.
//  - proc_core: compare/emit logic, have_last flag, optional deglitch reg.
// TESTING (LATENCY=2, CORE_DEGLITCH_EN off unless noted)
//  1. Hold reset=0 for 2 cycles, data_in=0x00 -> data_out=0x00 and valid=0
//     throughout reset.
//  2. Release reset with data_in=0x00 constant for 10 cycles -> exactly one
//     valid pulse with data_out=0x00, 2 edges after release.
//  3. data_in 0x00 -> 0xFF, 10 cycles later -> 0x55 -> one pulse each,
//     data_out=0xFF then 0x55, each 2 edges after its change.
//  4. data_in 0x11,0x22,0x11 on consecutive cycles -> three consecutive
//     pulses emitting 0x11,0x22,0x11.
//  5. Assert reset mid-stream while valid=1 -> valid and data_out go to 0
//     immediately, without a clock edge. Same value after release ->
//     re-emitted once.
//  6. CORE_DEGLITCH_EN: 1-cycle glitch 0x55->0xAA->0x55 -> no pulse for
//     0xAA; a 2-cycle 0xAA is emitted 3 edges after its first sample.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg - shared types and limits for the proc_core change-detect slice.
//
// Contents:
//   DEFAULT_DATA_W  default sample width (8)
//   LATENCY_MAX     deepest supported input-to-compare pipeline (4)
//   data_t          one sample, DEFAULT_DATA_W bits
//   stage_t         one pipeline slot: sample plus stage-valid bit
package core_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int LATENCY_MAX    = 4;

  typedef logic [DEFAULT_DATA_W-1:0] data_t;

  typedef struct packed {
    data_t d;
    logic  v;
  } stage_t;

endpackage

// File: rtl/core_stage.sv
// core_stage - one stage_t pipeline register of the proc_core delay line.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active low (0 = reset asserted)
//   stage_in   in   slot from the previous stage (or the input sampler)
//   stage_out  out  registered slot; data and valid cleared in reset
module core_stage
  import core_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  stage_t stage_in,
  output stage_t stage_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_out <= '0;
    end else begin
      stage_out <= stage_in;
    end
  end

endmodule

// File: rtl/proc_core.sv
// proc_core - byte-stream change-detect core.
//
// Samples data_in every clock, delays it LATENCY cycles through core_stage
// registers, and re-emits the delayed value on data_out with a one-cycle
// valid strobe whenever it differs from the last emitted value. The first
// sample after reset is always emitted.
//
// Parameters:
//   DATA_W   sample width; must equal core_pkg::DEFAULT_DATA_W because the
//            pipeline slots use the package-sized stage_t
//   LATENCY  input-to-compare pipeline depth, 1..LATENCY_MAX
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous reset, active low (0 = reset asserted)
//   data_in   in   sample, captured every rising edge
//   data_out  out  last emitted value (registered)
//   valid     out  one-cycle strobe: data_out was updated this cycle
//
// Build option:
//   CORE_DEGLITCH_EN  when defined, a tail value is emitted only if it equals
//                     the tail value of the previous cycle; this suppresses
//                     single-cycle glitches at the cost of one extra cycle.
module proc_core
  import core_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid
);

  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("proc_core: LATENCY must be in 1..LATENCY_MAX");
  end

  // chain[0] is the unregistered input slot; chain[LATENCY] is the tail.
  stage_t chain [LATENCY+1];
  stage_t tail;
  logic   have_last;
  logic   emit;

  assign chain[0] = '{d: data_in, v: 1'b1};

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    core_stage u_stage (
      .clk       (clk),
      .reset     (reset),
      .stage_in  (chain[i]),
      .stage_out (chain[i+1])
    );
  end

  assign tail = chain[LATENCY];

`ifdef CORE_DEGLITCH_EN
  // Previous tail slot; its valid bit keeps the very first post-reset
  // sample from being emitted until a second equal sample arrives.
  stage_t prev_tail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_tail <= '0;
    end else begin
      prev_tail <= tail;
    end
  end

  always_comb begin
    emit = 1'b0;
    if (tail.v && prev_tail.v && (tail.d == prev_tail.d) &&
        (!have_last || (tail.d != data_out))) begin
      emit = 1'b1;
    end
  end
`else
  always_comb begin
    emit = 1'b0;
    if (tail.v && (!have_last || (tail.d != data_out))) begin
      emit = 1'b1;
    end
  end
`endif

  // Comparison is against the last emitted value only, so A-B-A emits all
  // three; have_last forces the first sample out even when it is zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid     <= 1'b0;
      have_last <= 1'b0;
    end else if (emit) begin
      data_out  <= tail.d;
      valid     <= 1'b1;
      have_last <= 1'b1;
    end else begin
      valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_core.sv
// tb_proc_core - self-checking bench for proc_core (LATENCY = 2).
//
// Stimulus tasks push expected emissions (value plus the edge at which the
// pulse is due) into a queue from a behavioural model of the change-detect
// rule; a monitor pops and compares whenever a pulse is due or seen.
// Build with +define+CORE_DEGLITCH_EN to exercise the deglitch option.
module tb_proc_core;

  localparam int LAT = 2;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid;

  exp_t       exp_q[$];
  int         cyc;
  int         n_checks;
  int         n_fail;
  int         pulse_count;
  logic [7:0] exp_out;

  // behavioural model state
  logic       m_have_last;
  logic [7:0] m_last;
  logic       m_have_prev;
  logic [7:0] m_prev;

  proc_core #(.DATA_W(8), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t e;
    logic exp_valid;
    #1;
    cyc++;
    if (reset) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      exp_valid = (exp_q.size() > 0 && exp_q[0].due == cyc);
      n_checks++;
      if (valid !== exp_valid) begin
        n_fail++;
        $display("[TB] FAIL sb_valid cycle %0d: got %b expected %b", cyc, valid, exp_valid);
      end
      if (exp_valid) begin
        e = exp_q.pop_front();
        exp_out = e.d;
      end
      n_checks++;
      if (data_out !== exp_out) begin
        n_fail++;
        $display("[TB] FAIL sb_data_out cycle %0d: got %02h expected %02h", cyc, data_out, exp_out);
      end
      if (valid === 1'b1) pulse_count++;
    end
  end

  task automatic model_reset();
    exp_q.delete();
    exp_out     = 8'h00;
    m_have_last = 1'b0;
    m_last      = 8'h00;
    m_have_prev = 1'b0;
    m_prev      = 8'h00;
  endtask

  // Drive one sample for the next edge and record the expected emission.
  task automatic drive_cycle(input logic [7:0] x);
    logic emit;
    exp_t e;
    data_in = x;
`ifdef CORE_DEGLITCH_EN
    emit = m_have_prev && (x == m_prev) && (!m_have_last || x != m_last);
    m_have_prev = 1'b1;
    m_prev      = x;
`else
    emit = !m_have_last || (x != m_last);
`endif
    if (emit) begin
      e.d   = x;
      e.due = cyc + 1 + LAT;
      exp_q.push_back(e);
      m_have_last = 1'b1;
      m_last      = x;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    data_in = 8'h00;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #2;
      n_checks++;
      if (data_out !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL reset_data_out: got %02h expected 00", data_out);
      end
      n_checks++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_valid: got %b expected 0", valid);
      end
    end
  endtask

  task automatic test_first_sample();
    pulse_count = 0;
    reset = 1'b1;
    repeat (10) drive_cycle(8'h00);
    n_checks++;
    if (pulse_count !== 1) begin
      n_fail++;
      $display("[TB] FAIL first_sample_pulses: got %0d expected 1", pulse_count);
    end
  endtask

  task automatic test_changes();
    pulse_count = 0;
    repeat (10) drive_cycle(8'hFF);
    repeat (10) drive_cycle(8'h55);
    n_checks++;
    if (pulse_count !== 2) begin
      n_fail++;
      $display("[TB] FAIL change_pulses: got %0d expected 2", pulse_count);
    end
    n_checks++;
    if (data_out !== 8'h55) begin
      n_fail++;
      $display("[TB] FAIL change_final: got %02h expected 55", data_out);
    end
  endtask

  task automatic test_back_to_back();
    int exp_pulses;
`ifdef CORE_DEGLITCH_EN
    exp_pulses = 1;
`else
    exp_pulses = 3;
`endif
    pulse_count = 0;
    drive_cycle(8'h11);
    drive_cycle(8'h22);
    repeat (5) drive_cycle(8'h11);
    n_checks++;
    if (pulse_count !== exp_pulses) begin
      n_fail++;
      $display("[TB] FAIL aba_pulses: got %0d expected %0d", pulse_count, exp_pulses);
    end
  endtask

  task automatic test_mid_reset();
    int extra;
`ifdef CORE_DEGLITCH_EN
    extra = 1;
`else
    extra = 0;
`endif
    repeat (3 + extra) drive_cycle(8'h33);
    n_checks++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_pre_valid: got %b expected 1", valid);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_async_valid: got %b expected 0", valid);
    end
    n_checks++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL midreset_async_data_out: got %02h expected 00", data_out);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    pulse_count = 0;
    repeat (8) drive_cycle(8'h33);
    n_checks++;
    if (pulse_count !== 1) begin
      n_fail++;
      $display("[TB] FAIL midreset_reemit_pulses: got %0d expected 1", pulse_count);
    end
  endtask

`ifdef CORE_DEGLITCH_EN
  task automatic test_deglitch();
    repeat (4) drive_cycle(8'h55);
    pulse_count = 0;
    drive_cycle(8'hAA);
    repeat (4) drive_cycle(8'h55);
    n_checks++;
    if (pulse_count !== 0) begin
      n_fail++;
      $display("[TB] FAIL deglitch_glitch_pulses: got %0d expected 0", pulse_count);
    end
    repeat (2) drive_cycle(8'hAA);
    repeat (4) drive_cycle(8'h55);
    n_checks++;
    if (pulse_count !== 2) begin
      n_fail++;
      $display("[TB] FAIL deglitch_stable_pulses: got %0d expected 2", pulse_count);
    end
  endtask
`endif

  initial begin
    cyc         = 0;
    n_checks    = 0;
    n_fail      = 0;
    pulse_count = 0;
    test_reset();
    test_first_sample();
    test_changes();
    test_back_to_back();
    test_mid_reset();
`ifdef CORE_DEGLITCH_EN
    test_deglitch();
`endif
    repeat (4) drive_cycle(data_in);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
